// File: rtl/mod_reduct_solinas2_arb.sv
// Round-robin arbiter sharing one Solinas reducer among NB_REQ requesters.
// Optional MOD_REDUCT_SOLINAS2_ARB_ERR_EN adds a sticky err output.
module mod_reduct_solinas2_arb #(
    parameter int NB_REQ     = 4,
    parameter int MOD_W      = 64,
    parameter int OP_W       = 2*MOD_W,
    parameter int RED_LAT    = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int ID_W      = $clog2(NB_REQ)
) (
    input  logic                     clk,
    input  logic                     s_rst_n,
    input  logic [NB_REQ-1:0]        req_vld,
    output logic [NB_REQ-1:0]        req_rdy,
    input  logic [NB_REQ*OP_W-1:0]   req_data,
    output logic [OP_W-1:0]          red_a,
    output logic                     red_in_avail,
    output logic [ID_W-1:0]          red_in_side,
    input  logic [MOD_W-1:0]         red_z,
    input  logic                     red_out_avail,
    input  logic [ID_W-1:0]          red_out_side,
    output logic [NB_REQ-1:0]        rsp_vld,
    input  logic [NB_REQ-1:0]        rsp_rdy,
    output logic [NB_REQ*MOD_W-1:0]  rsp_data
`ifdef MOD_REDUCT_SOLINAS2_ARB_ERR_EN
   ,output logic                     err
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    if (NB_REQ < 2 || FIFO_DEPTH < 1 || RED_LAT < 1) begin : g_bad_cfg
        $error("mod_reduct_solinas2_arb: illegal parameters");
    end

    logic [NB_REQ-1:0] elig;
    logic [NB_REQ-1:0] grant;
    logic [NB_REQ-1:0] pop;
    logic [NB_REQ-1:0] push;
    logic [NB_REQ-1:0] full;
    logic              gv;
    logic [ID_W-1:0]   gid;
    logic [ID_W-1:0]   idx;
    logic [ID_W-1:0]   ptr;

    logic [CW-1:0]     credit [NB_REQ];
    logic [CW-1:0]     cnt    [NB_REQ];
    logic [CW-1:0]     cnt_n  [NB_REQ];
    logic [PW-1:0]     rd     [NB_REQ];
    logic [PW-1:0]     wr     [NB_REQ];
    logic [PW-1:0]     rd_n   [NB_REQ];
    logic [PW-1:0]     wr_n   [NB_REQ];
    logic [MOD_W-1:0]  head_n [NB_REQ];
    logic [MOD_W-1:0]  mem    [NB_REQ][FIFO_DEPTH];

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        elig  = '0;
        grant = '0;
        gv    = 1'b0;
        gid   = '0;
        idx   = '0;
        for (int i = 0; i < NB_REQ; i++)
            elig[i] = req_vld[i] && (credit[i] != '0);
        for (int k = 0; k < NB_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NB_REQ);
            if (!gv && elig[idx]) begin
                gv  = 1'b1;
                gid = idx;
            end
        end
        if (gv)
            grant[gid] = 1'b1;
    end

    // Gated by reset so the handshake is dead while reset is held.
    assign req_rdy = grant & {NB_REQ{s_rst_n}};

    always_comb begin
        for (int i = 0; i < NB_REQ; i++) begin
            pop[i]  = rsp_vld[i] & rsp_rdy[i];
            full[i] = (cnt[i] == CW'(FIFO_DEPTH));
            push[i] = red_out_avail && (red_out_side == ID_W'(i))
                      && (!full[i] || pop[i]);
            cnt_n[i] = cnt[i] + CW'(push[i]) - CW'(pop[i]);
            rd_n[i]  = pop[i]  ? inc(rd[i]) : rd[i];
            wr_n[i]  = push[i] ? inc(wr[i]) : wr[i];
            // An entry pushed into an (effectively) empty FIFO becomes head.
            if ((cnt[i] - CW'(pop[i])) == '0)
                head_n[i] = red_z;
            else
                head_n[i] = mem[i][rd_n[i]];
        end
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            ptr          <= '0;
            red_in_avail <= 1'b0;
            red_a        <= '0;
            red_in_side  <= '0;
            rsp_vld      <= '0;
            rsp_data     <= '0;
            for (int i = 0; i < NB_REQ; i++) begin
                credit[i] <= CW'(FIFO_DEPTH);
                cnt[i]    <= '0;
                rd[i]     <= '0;
                wr[i]     <= '0;
            end
        end else begin
            red_in_avail <= gv;
            if (gv) begin
                red_a       <= req_data[int'(gid)*OP_W +: OP_W];
                red_in_side <= gid;
                ptr <= (gid == ID_W'(NB_REQ-1)) ? '0 : gid + ID_W'(1);
            end
            for (int i = 0; i < NB_REQ; i++) begin
                if (grant[i] && !pop[i])
                    credit[i] <= credit[i] - CW'(1);
                else if (pop[i] && !grant[i]
                         && credit[i] != CW'(FIFO_DEPTH))
                    credit[i] <= credit[i] + CW'(1);
                cnt[i]     <= cnt_n[i];
                rd[i]      <= rd_n[i];
                wr[i]      <= wr_n[i];
                rsp_vld[i] <= (cnt_n[i] != '0);
                if (cnt_n[i] != '0)
                    rsp_data[i*MOD_W +: MOD_W] <= head_n[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB_REQ; i++)
            if (push[i])
                mem[i][wr[i]] <= red_z;
    end

`ifdef MOD_REDUCT_SOLINAS2_ARB_ERR_EN
    // Any result that found no FIFO to land in was dropped.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n)
            err <= 1'b0;
        else if (red_out_avail && (push == '0))
            err <= 1'b1;
    end
`endif

endmodule
